// File: rtl/ibex_wb_arbiter.sv
// ibex_wb_arbiter
//
// Write-back arbiter between a single-cycle execute result and one
// outstanding load. It owns the register file write port and forwards
// operands to decode.
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   ex_valid_i/ex_ready_o  execute result handshake (ex_waddr_i, ex_wdata_i)
//   lsu_issue_i, lsu_rd_i  load issue and its destination register
//   lsu_issue_ready_o      a load may be issued (none outstanding)
//   lsu_rvalid_i           load response, with lsu_rdata_i and lsu_err_i
//   rf_we_o/waddr/wdata    register file write port
//   raddr_a_i/raddr_b_i    decode read addresses; rf_rdata_*_i raw file data
//   rdata_a_o/rdata_b_o    forwarded operands
//   stall_o                an operand depends on the outstanding load
//   load_pending_o         a load is outstanding (FSM in LOAD_WAIT)
//
// Handshake: an execute result transfers in a cycle where ex_valid_i and
// ex_ready_o are both high. ex_ready_o is derived only from registered
// state and the current inputs, so the producer may sample it in the same
// cycle. A result that is not accepted must be presented again.

module ibex_wb_arbiter #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 ex_valid_i,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    output logic                 ex_ready_o,

    input  logic                 lsu_issue_i,
    input  logic [4:0]           lsu_rd_i,
    output logic                 lsu_issue_ready_o,

    input  logic                 lsu_rvalid_i,
    input  logic [DataWidth-1:0] lsu_rdata_i,
    input  logic                 lsu_err_i,

    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,

    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    input  logic [DataWidth-1:0] rf_rdata_a_i,
    input  logic [DataWidth-1:0] rf_rdata_b_i,

    output logic [DataWidth-1:0] rdata_a_o,
    output logic [DataWidth-1:0] rdata_b_o,
    output logic                 stall_o,
    output logic                 load_pending_o
);

    localparam logic [0:0] StIdle     = 1'b0;
    localparam logic [0:0] StLoadWait = 1'b1;

    // RV32E only has x0..x15, so the top address bit is dropped everywhere.
    localparam logic [4:0] AddrMask = RV32E ? 5'h0F : 5'h1F;

    logic [0:0]           state_q, state_d;
    logic [4:0]           pend_rd_q, pend_rd_d;
    logic                 skid_valid_q, skid_valid_d;
    logic [4:0]           skid_waddr_q, skid_waddr_d;
    logic [DataWidth-1:0] skid_wdata_q, skid_wdata_d;

    logic [4:0]           ex_addr, lsu_addr, ra_addr, rb_addr;
    logic                 load_wait;
    logic                 load_wr;
    logic                 waw_hold;
    logic                 ex_acc;
    logic                 skid_drain;
    logic                 skid_capture;
    logic                 sel_we;
    logic [4:0]           sel_addr;
    logic [DataWidth-1:0] sel_data;

    assign ex_addr  = ex_waddr_i & AddrMask;
    assign lsu_addr = lsu_rd_i   & AddrMask;
    assign ra_addr  = raddr_a_i  & AddrMask;
    assign rb_addr  = raddr_b_i  & AddrMask;

    assign load_wait = (state_q == StLoadWait);
    // An erroneous response still ends the load but never writes.
    assign load_wr   = load_wait & lsu_rvalid_i & ~lsu_err_i;

    // Hold a younger execute write to the load's destination until the
    // response arrives; it then goes through the skid so it lands after
    // the load data and the final register value is the execute one.
    assign waw_hold = load_wait & ex_valid_i & (ex_addr == pend_rd_q) &
                      (pend_rd_q != 5'd0) & ~lsu_rvalid_i;

    assign ex_ready_o = ~skid_valid_q & ~waw_hold;
    assign ex_acc     = ex_valid_i & ex_ready_o;

    assign lsu_issue_ready_o = (state_q == StIdle);
    assign load_pending_o    = load_wait;

    // Write port source select: load response, then skid, then execute.
    // An execute result is never accepted while the skid is full.
    always_comb begin
        sel_we     = 1'b0;
        sel_addr   = 5'd0;
        sel_data   = '0;
        skid_drain = 1'b0;
        if (load_wr) begin
            sel_we   = 1'b1;
            sel_addr = pend_rd_q;
            sel_data = lsu_rdata_i;
        end else if (skid_valid_q) begin
            sel_we     = 1'b1;
            sel_addr   = skid_waddr_q;
            sel_data   = skid_wdata_q;
            skid_drain = 1'b1;
        end else if (ex_acc) begin
            sel_we   = 1'b1;
            sel_addr = ex_addr;
            sel_data = ex_wdata_i;
        end
    end

    // Writes to x0 are dropped; idle write port is driven to zero.
    assign rf_we_o    = sel_we & (sel_addr != 5'd0);
    assign rf_waddr_o = rf_we_o ? sel_addr : 5'd0;
    assign rf_wdata_o = rf_we_o ? sel_data : '0;

    // An accepted execute result that lost to the load is parked in the
    // skid. A result for x0 has nothing to write, so it is simply consumed.
    assign skid_capture = ex_acc & load_wr & (ex_addr != 5'd0);

    always_comb begin
        skid_valid_d = skid_valid_q;
        skid_waddr_d = skid_waddr_q;
        skid_wdata_d = skid_wdata_q;
        if (skid_drain) begin
            skid_valid_d = 1'b0;
        end
        if (skid_capture) begin
            skid_valid_d = 1'b1;
            skid_waddr_d = ex_addr;
            skid_wdata_d = ex_wdata_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_rd_d = pend_rd_q;
        if (state_q == StIdle) begin
            if (lsu_issue_i) begin
                state_d   = StLoadWait;
                pend_rd_d = lsu_addr;
            end
        end else begin
            if (lsu_rvalid_i) begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            pend_rd_q    <= 5'd0;
            skid_valid_q <= 1'b0;
            skid_waddr_q <= 5'd0;
            skid_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            pend_rd_q    <= pend_rd_d;
            skid_valid_q <= skid_valid_d;
            skid_waddr_q <= skid_waddr_d;
            skid_wdata_q <= skid_wdata_d;
        end
    end

    function automatic logic [DataWidth-1:0] fwd(
        input logic [4:0]           raddr,
        input logic [DataWidth-1:0] raw,
        input logic                 we,
        input logic [4:0]           waddr,
        input logic [DataWidth-1:0] wdata,
        input logic                 skv,
        input logic [4:0]           ska,
        input logic [DataWidth-1:0] skd
    );
        if (raddr == 5'd0) begin
            return '0;
        end else if (we && (waddr == raddr)) begin
            return wdata;
        end else if (skv && (ska == raddr)) begin
            return skd;
        end
        return raw;
    endfunction

    assign rdata_a_o = fwd(ra_addr, rf_rdata_a_i, rf_we_o, rf_waddr_o, rf_wdata_o,
                           skid_valid_q, skid_waddr_q, skid_wdata_q);
    assign rdata_b_o = fwd(rb_addr, rf_rdata_b_i, rf_we_o, rf_waddr_o, rf_wdata_o,
                           skid_valid_q, skid_waddr_q, skid_wdata_q);

    // The response cycle itself forwards the load data, so no stall then.
    assign stall_o = load_wait & (pend_rd_q != 5'd0) &
                     ((ra_addr == pend_rd_q) | (rb_addr == pend_rd_q)) & ~load_wr;

endmodule

// File: tb/tb_ibex_wb_arbiter.sv
// Bench for ibex_wb_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.

module tb_ibex_wb_arbiter;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          ex_valid_i;
    logic [4:0]    ex_waddr_i;
    logic [DW-1:0] ex_wdata_i;
    logic          ex_ready_o;
    logic          lsu_issue_i;
    logic [4:0]    lsu_rd_i;
    logic          lsu_issue_ready_o;
    logic          lsu_rvalid_i;
    logic [DW-1:0] lsu_rdata_i;
    logic          lsu_err_i;
    logic          rf_we_o;
    logic [4:0]    rf_waddr_o;
    logic [DW-1:0] rf_wdata_o;
    logic [4:0]    raddr_a_i;
    logic [4:0]    raddr_b_i;
    logic [DW-1:0] rf_rdata_a_i;
    logic [DW-1:0] rf_rdata_b_i;
    logic [DW-1:0] rdata_a_o;
    logic [DW-1:0] rdata_b_o;
    logic          stall_o;
    logic          load_pending_o;

    always #5 clk = ~clk;

    ibex_wb_arbiter #(.RV32E(1'b0), .DataWidth(DW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .ex_valid_i       (ex_valid_i),
        .ex_waddr_i       (ex_waddr_i),
        .ex_wdata_i       (ex_wdata_i),
        .ex_ready_o       (ex_ready_o),
        .lsu_issue_i      (lsu_issue_i),
        .lsu_rd_i         (lsu_rd_i),
        .lsu_issue_ready_o(lsu_issue_ready_o),
        .lsu_rvalid_i     (lsu_rvalid_i),
        .lsu_rdata_i      (lsu_rdata_i),
        .lsu_err_i        (lsu_err_i),
        .rf_we_o          (rf_we_o),
        .rf_waddr_o       (rf_waddr_o),
        .rf_wdata_o       (rf_wdata_o),
        .raddr_a_i        (raddr_a_i),
        .raddr_b_i        (raddr_b_i),
        .rf_rdata_a_i     (rf_rdata_a_i),
        .rf_rdata_b_i     (rf_rdata_b_i),
        .rdata_a_o        (rdata_a_o),
        .rdata_b_o        (rdata_b_o),
        .stall_o          (stall_o),
        .load_pending_o   (load_pending_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: one outstanding load, and a queue of execute writes
    // that lost the port to a load response and are owed to the file.
    typedef struct packed {
        logic [4:0]    a;
        logic [DW-1:0] d;
    } wr_t;

    bit            m_busy;
    logic [4:0]    m_rd;
    wr_t           owed_q[$];

    logic          e_ready, e_we, e_stall;
    logic [4:0]    e_waddr;
    logic [DW-1:0] e_wdata, e_ra, e_rb;
    bit            e_owe, e_paid;

    function automatic logic [DW-1:0] model_read(input logic [4:0] ra, input logic [DW-1:0] raw);
        if (ra == 5'd0) return '0;
        if (e_we && e_waddr == ra) return e_wdata;
        if (owed_q.size() != 0 && owed_q[0].a == ra) return owed_q[0].d;
        return raw;
    endfunction

    task automatic model_eval();
        bit  resp_ok, ex_acc, have;
        wr_t w;
        w       = '0;
        have    = 1'b1;
        e_paid  = 1'b0;
        resp_ok = m_busy && lsu_rvalid_i && !lsu_err_i;
        e_ready = (owed_q.size() == 0) &&
                  !(m_busy && ex_valid_i && ex_waddr_i == m_rd && m_rd != 5'd0 && !lsu_rvalid_i);
        ex_acc  = ex_valid_i && e_ready;
        if (resp_ok) begin
            w.a = m_rd;
            w.d = lsu_rdata_i;
        end else if (owed_q.size() != 0) begin
            w      = owed_q[0];
            e_paid = 1'b1;
        end else if (ex_acc) begin
            w.a = ex_waddr_i;
            w.d = ex_wdata_i;
        end else begin
            have = 1'b0;
        end
        e_we    = have && (w.a != 5'd0);
        e_waddr = e_we ? w.a : 5'd0;
        e_wdata = e_we ? w.d : '0;
        e_owe   = ex_acc && resp_ok && (ex_waddr_i != 5'd0);
        e_stall = m_busy && (m_rd != 5'd0) &&
                  (raddr_a_i == m_rd || raddr_b_i == m_rd) && !resp_ok;
        e_ra    = model_read(raddr_a_i, rf_rdata_a_i);
        e_rb    = model_read(raddr_b_i, rf_rdata_b_i);
    endtask

    task automatic model_update();
        wr_t w;
        if (!rst_ni) begin
            m_busy = 1'b0;
            m_rd   = 5'd0;
            owed_q.delete();
        end else begin
            if (e_paid) void'(owed_q.pop_front());
            if (e_owe) begin
                w.a = ex_waddr_i;
                w.d = ex_wdata_i;
                owed_q.push_back(w);
            end
            if (m_busy) begin
                if (lsu_rvalid_i) m_busy = 1'b0;
            end else if (lsu_issue_i) begin
                m_busy = 1'b1;
                m_rd   = lsu_rd_i;
            end
        end
    endtask

    task automatic idle_inputs();
        rst_ni       = 1'b1;
        ex_valid_i   = 1'b0;
        ex_waddr_i   = 5'd0;
        ex_wdata_i   = '0;
        lsu_issue_i  = 1'b0;
        lsu_rd_i     = 5'd0;
        lsu_rvalid_i = 1'b0;
        lsu_rdata_i  = '0;
        lsu_err_i    = 1'b0;
        raddr_a_i    = 5'd0;
        raddr_b_i    = 5'd0;
        rf_rdata_a_i = 32'hA5A5_0001;
        rf_rdata_b_i = 32'hA5A5_0002;
    endtask

    // Inputs are driven 1 time unit after the rising edge; outputs are
    // compared on the falling edge.
    task automatic eval_check(input string tag);
        #4;
        model_eval();
        check_eq({tag, ".ex_ready"}, ex_ready_o, e_ready);
        check_eq({tag, ".we"}, rf_we_o, e_we);
        check_eq({tag, ".waddr"}, rf_waddr_o, e_waddr);
        check_eq({tag, ".wdata"}, rf_wdata_o, e_wdata);
        check_eq({tag, ".rdata_a"}, rdata_a_o, e_ra);
        check_eq({tag, ".rdata_b"}, rdata_b_o, e_rb);
        check_eq({tag, ".stall"}, stall_o, e_stall);
        check_eq({tag, ".pending"}, load_pending_o, m_busy);
        check_eq({tag, ".issue_ready"}, lsu_issue_ready_o, !m_busy);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        m_busy = 1'b0;
        m_rd   = 5'd0;
        owed_q.delete();
        #1;

        // Reset values
        idle_inputs();
        eval_check("reset");
        check_eq("reset_ready", ex_ready_o, 1);
        check_eq("reset_issue_ready", lsu_issue_ready_o, 1);
        tick();

        // Execute write in IDLE, same cycle
        ex_valid_i = 1'b1; ex_waddr_i = 5'd5; ex_wdata_i = 32'h1234;
        eval_check("ex_x5");
        check_eq("ex_x5_we", rf_we_o, 1);
        check_eq("ex_x5_addr", rf_waddr_o, 5);
        check_eq("ex_x5_data", rf_wdata_o, 32'h1234);
        tick();

        // Load x7, dependent read stalls until response
        idle_inputs(); lsu_issue_i = 1'b1; lsu_rd_i = 5'd7;
        eval_check("ld7_issue"); tick();
        for (int i = 0; i < 2; i++) begin
            idle_inputs(); raddr_a_i = 5'd7;
            eval_check("ld7_wait");
            check_eq("ld7_stall", stall_o, 1);
            tick();
        end
        idle_inputs(); raddr_a_i = 5'd7; lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'hCAFE;
        eval_check("ld7_resp");
        check_eq("ld7_resp_stall", stall_o, 0);
        check_eq("ld7_resp_fwd", rdata_a_o, 32'hCAFE);
        check_eq("ld7_resp_addr", rf_waddr_o, 7);
        tick();

        // Load response and execute result collide
        idle_inputs(); lsu_issue_i = 1'b1; lsu_rd_i = 5'd7;
        eval_check("col_issue"); tick();
        idle_inputs(); lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'hBEEF;
        ex_valid_i = 1'b1; ex_waddr_i = 5'd3; ex_wdata_i = 32'h11;
        eval_check("col_resp");
        check_eq("col_resp_addr", rf_waddr_o, 7);
        tick();
        idle_inputs(); raddr_b_i = 5'd3;
        eval_check("col_skid");
        check_eq("col_skid_ready", ex_ready_o, 0);
        check_eq("col_skid_addr", rf_waddr_o, 3);
        check_eq("col_skid_data", rf_wdata_o, 32'h11);
        tick();

        // WAW hold against pending x4, load errors out
        idle_inputs(); lsu_issue_i = 1'b1; lsu_rd_i = 5'd4;
        eval_check("waw_issue"); tick();
        idle_inputs(); ex_valid_i = 1'b1; ex_waddr_i = 5'd4; ex_wdata_i = 32'h44;
        eval_check("waw_hold");
        check_eq("waw_hold_ready", ex_ready_o, 0);
        tick();
        lsu_rvalid_i = 1'b1; lsu_err_i = 1'b1; lsu_rdata_i = 32'hBAD;
        eval_check("waw_err");
        check_eq("waw_err_data", rf_wdata_o, 32'h44);
        tick();
        idle_inputs();
        eval_check("waw_after");
        check_eq("waw_after_pending", load_pending_o, 0);
        tick();

        // x0 write and x0 read
        ex_valid_i = 1'b1; ex_waddr_i = 5'd0; ex_wdata_i = 32'h99;
        raddr_b_i = 5'd0; rf_rdata_b_i = 32'hFFFF_FFFF;
        eval_check("x0");
        check_eq("x0_we", rf_we_o, 0);
        check_eq("x0_ready", ex_ready_o, 1);
        check_eq("x0_rdata_b", rdata_b_o, 0);
        tick();

        // Reset during LOAD_WAIT discards the load
        idle_inputs(); lsu_issue_i = 1'b1; lsu_rd_i = 5'd6;
        eval_check("rstld_issue"); tick();
        idle_inputs(); rst_ni = 1'b0;
        eval_check("rstld_rst"); tick();
        idle_inputs();
        eval_check("rstld_after");
        check_eq("rstld_pending", load_pending_o, 0);
        tick();
        lsu_rvalid_i = 1'b1; lsu_rdata_i = 32'h66;
        eval_check("rstld_late");
        check_eq("rstld_late_we", rf_we_o, 0);
        tick();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rst_ni       = ($urandom_range(0, 49) != 0);
            ex_valid_i   = $urandom_range(0, 1);
            ex_waddr_i   = 5'($urandom_range(0, 7));
            ex_wdata_i   = $urandom;
            lsu_issue_i  = ($urandom_range(0, 9) < 3);
            lsu_rd_i     = 5'($urandom_range(0, 7));
            lsu_rvalid_i = ($urandom_range(0, 9) < 3);
            lsu_rdata_i  = $urandom;
            lsu_err_i    = ($urandom_range(0, 4) == 0);
            raddr_a_i    = 5'($urandom_range(0, 7));
            raddr_b_i    = 5'($urandom_range(0, 7));
            rf_rdata_a_i = $urandom;
            rf_rdata_b_i = $urandom;
            eval_check("rand");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ibex_wb_arbiter.md
IBEX_WB_ARBITER -- requirements
Module: ibex_wb_arbiter

Interface
REQ-001 SHALL have parameter RV32E, default 0: 1 limits register addresses to x0..x15 (upper address bit ignored).
REQ-002 SHALL have parameter DataWidth, default 32: register data width.
REQ-003 SHALL have port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have ex_valid_i in 1, ex_waddr_i in 5, ex_wdata_i in DataWidth: single-cycle execute result.
REQ-006 SHALL have ex_ready_o, output, 1: execute result accepted this cycle.
REQ-007 SHALL have lsu_issue_i in 1 and lsu_rd_i in 5: load issued, with destination register.
REQ-008 SHALL have lsu_issue_ready_o, output, 1: a load may be issued (no load outstanding).
REQ-009 SHALL have lsu_rvalid_i in 1, lsu_rdata_i in DataWidth, lsu_err_i in 1: load response.
REQ-010 SHALL have rf_we_o out 1, rf_waddr_o out 5, rf_wdata_o out DataWidth: register file write port.
REQ-011 SHALL have raddr_a_i/raddr_b_i in 5 and rf_rdata_a_i/rf_rdata_b_i in DataWidth: decode read addresses and raw register file data.
REQ-012 SHALL have rdata_a_o/rdata_b_o out DataWidth: forwarded operands; stall_o out 1: operand hazard; load_pending_o out 1.

Function
REQ-013 SHALL implement FSM IDLE/LOAD_WAIT: IDLE->LOAD_WAIT on lsu_issue_i && lsu_issue_ready_o; LOAD_WAIT->IDLE on lsu_rvalid_i.
REQ-014 SHALL latch lsu_rd_i into pend_rd on accepted issue; lsu_issue_ready_o = (state==IDLE); load_pending_o = (state==LOAD_WAIT).
REQ-015 SHALL ignore lsu_issue_i while in LOAD_WAIT, and lsu_rvalid_i while in IDLE (no write, no state change).
REQ-016 SHALL hold one-entry skid register (skid_valid, skid_waddr, skid_wdata).
REQ-017 SHALL drive write port, priority: (1) load response in LOAD_WAIT without lsu_err_i -> pend_rd/lsu_rdata_i; (2) skid entry; (3) accepted ex result.
REQ-018 SHALL deassert ex_ready_o when skid_valid=1, or when LOAD_WAIT, ex_valid_i=1, ex_waddr_i==pend_rd, pend_rd!=0 and lsu_rvalid_i=0 (WAW hold).
REQ-019 SHALL, when an accepted ex result collides with a load write in the same cycle, capture it into the skid (skid_valid=1), drained the next cycle.
REQ-020 SHALL clear skid_valid in the cycle the skid entry is written.
REQ-021 SHALL force rf_we_o=0 for any write whose address is 0; such an accepted ex result is consumed (ex_ready_o=1) without writing.
REQ-022 SHALL, on lsu_err_i with lsu_rvalid_i, perform no register write but still return to IDLE.
REQ-023 SHALL drive rf_we_o, rf_waddr_o, rf_wdata_o combinationally in the same cycle as the winning source (zero added latency); rf_waddr_o/rf_wdata_o = 0 when rf_we_o=0.
REQ-024 SHALL forward per read port: raddr==0 -> 0; else match rf_waddr_o with rf_we_o=1 -> rf_wdata_o; else skid_valid match -> skid_wdata; else rf_rdata_*_i.
REQ-025 SHALL assert stall_o when LOAD_WAIT, pend_rd!=0, either raddr equals pend_rd, and no error-free lsu_rvalid_i this cycle.
REQ-026 SHALL compare only address bits [3:0] when RV32E=1.

Reset
REQ-027 SHALL, when rst_ni=0 at a rising edge, set state=IDLE, skid_valid=0, pend_rd=0, skid_waddr/skid_wdata=0.
REQ-028 SHALL, with registers at reset values, give rf_we_o=0, stall_o=0, load_pending_o=0, lsu_issue_ready_o=1, ex_ready_o=1.
REQ-029 SHALL, on reset during LOAD_WAIT or with skid_valid=1, discard the pending load and skid entry; a later lsu_rvalid_i produces no write.

Verification
REQ-030 SHALL cover: ex_valid_i, x5, 0x1234 in IDLE -> same cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0x1234, ex_ready_o=1.
REQ-031 SHALL cover: issue load x7; raddr_a_i=7 next cycle -> stall_o=1 until lsu_rvalid_i with 0xCAFE; that cycle stall_o=0, rdata_a_o=0xCAFE, write x7.
REQ-032 SHALL cover: load x7 response + ex x3=0x11 same cycle -> load written, x3 skidded, ex_ready_o=0 next cycle, x3=0x11 written next cycle.
REQ-033 SHALL cover: LOAD_WAIT pend_rd=4, ex writes x4 -> ex_ready_o=0 until response; load err -> no write to x4, then ex x4 written.
REQ-034 SHALL cover: ex write to x0 -> rf_we_o=0, ex_ready_o=1; raddr_b_i=0 -> rdata_b_o=0 regardless of rf_rdata_b_i.
REQ-035 SHALL cover: rst_ni=0 during LOAD_WAIT -> next cycle load_pending_o=0; subsequent lsu_rvalid_i causes no write.
